// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr
// Registered N-to-1 channel multiplexer with fixed-select or round-robin
// arbitration. The selected word goes into a one-entry output register.
// Both sides of that register use valid/ready handshakes.
//
// Parameters:
//   N    number of input channels (2..16)
//   W    data width per channel
//   SELW derived select / channel-id width, $clog2(N)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in fixed-select mode
//   in_data    packed channel data, channel i at [i*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected data
//   out_chan   channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
//   xfer_cnt   saturating count of accepted transfers (only with MUX_XFER_CNT_EN)
//
// Optional feature macro: MUX_XFER_CNT_EN

module mux_nto1_rr #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_chan,
   output logic              out_valid,
   input  logic              out_ready
`ifdef MUX_XFER_CNT_EN
   ,
   output logic [15:0]       xfer_cnt
`endif
);

   logic            outValid_q, outValid_d;
   logic [W-1:0]    outData_q,  outData_d;
   logic [SELW-1:0] outChan_q,  outChan_d;
   logic [SELW-1:0] rrPtr_q,    rrPtr_d;

   logic            loadEn;
   logic            grantValid;
   logic [SELW-1:0] grantIdx;
   logic            transfer;

   // Modulo-N add of a channel index and a small offset. Both operands are
   // below N, so one conditional subtract is enough to wrap.
   function automatic logic [SELW-1:0] wrapAdd(input logic [SELW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N) sum = sum - N;
      return SELW'(sum);
   endfunction

   // The output register can take a new word when it is empty or when it is
   // being drained in this same cycle. This gives full throughput.
   assign loadEn = !outValid_q || out_ready;

   // Grant selection.
   // In fixed mode, sel is matched against each real channel index, so an
   // out-of-range sel never produces a grant.
   // In round-robin mode, channels are scanned from the farthest offset down
   // to the nearest. The last hit, which is the nearest valid channel at or
   // after rrPtr_q, wins.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grantValid = 1'b1;
               grantIdx   = SELW'(i);
            end
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[wrapAdd(rrPtr_q, k)]) begin
               grantValid = 1'b1;
               grantIdx   = wrapAdd(rrPtr_q, k);
            end
         end
      end
   end

   assign transfer = loadEn && grantValid;

   // Ready goes only to the granted channel, and only when the register can
   // load this cycle.
   always_comb begin
      in_ready = '0;
      if (transfer) in_ready[grantIdx] = 1'b1;
   end

   // Next-state for the output register and the round-robin pointer.
   // A transfer loads the new word and moves the pointer past the granted
   // channel, in either mode. This lets a later switch to round-robin resume
   // fairly. A drain with no reload only clears valid, so data and channel
   // keep their last values.
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outChan_d  = outChan_q;
      rrPtr_d    = rrPtr_q;
      if (transfer) begin
         outValid_d = 1'b1;
         outData_d  = in_data[grantIdx*W +: W];
         outChan_d  = grantIdx;
         rrPtr_d    = (grantIdx == SELW'(N - 1)) ? '0 : grantIdx + 1'b1;
      end else if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // State registers. Reset discards any word held in the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outChan_q  <= '0;
         rrPtr_q    <= '0;
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outChan_q  <= outChan_d;
         rrPtr_q    <= rrPtr_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_chan  = outChan_q;

`ifdef MUX_XFER_CNT_EN
   logic [15:0] xferCnt_q, xferCnt_d;

   // Transfer counter. It sticks at all-ones instead of wrapping.
   always_comb begin
      xferCnt_d = xferCnt_q;
      if (transfer && xferCnt_q != 16'hFFFF) xferCnt_d = xferCnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xferCnt_q <= '0;
      else        xferCnt_q <= xferCnt_d;
   end

   assign xfer_cnt = xferCnt_q;
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr
// Self-checking bench for mux_nto1_rr with N=4, W=8. It runs four phases:
//   - a table of hand-computed vectors,
//   - hand-written reset and fairness sequences,
//   - randomized traffic checked against a behavioural model,
//   - the saturating counter test (only when MUX_XFER_CNT_EN is defined).

module tb_mux_nto1_rr;

   localparam int N = 4;
   localparam int W = 8;

   logic          clk;
   logic          rst_n;
   logic          mode;
   logic [1:0]    sel;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    out_chan;
   logic          out_valid;
   logic          out_ready;
`ifdef MUX_XFER_CNT_EN
   logic [15:0]   xfer_cnt;
`endif

   int checks = 0;
   int errors = 0;

   mux_nto1_rr #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MUX_XFER_CNT_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic [3:0] valid;
      logic       outReady;
      logic [3:0] expReady;
      logic       expValid;
      logic [7:0] expData;
      logic [1:0] expChan;
   } vec_t;

   vec_t vecs[16];

   // Behavioural reference state: the word the consumer should see, and the
   // channel the round-robin scan starts from.
   logic       mValid;
   logic [7:0] mData;
   int         mChan;
   int         mPtr;

   task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic [31:0] d, input logic r);
      mode      = m;
      sel       = s;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference grant rule, written directly from the selection rules:
   //   - fixed mode: the named channel wins if it is in range and valid;
   //   - round-robin: the first valid channel at or after the pointer, modulo N.
   function automatic int modelGrant(input logic m, input logic [1:0] s, input logic [3:0] v, input int ptr);
      if (!m) return (int'(s) < N && v[s]) ? int'(s) : -1;
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // One randomized cycle.
   //   - Before the clock edge, check in_ready against the model.
   //   - Advance the model across the edge.
   //   - After the edge, check the registered outputs.
   task automatic randomCycle();
      logic       m, r;
      logic [1:0] s;
      logic [3:0] v;
      logic [31:0] d;
      int g;
      logic canLoad;
      m = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      v = 4'($urandom_range(0, 15));
      d = $urandom;
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(m, s, v, d, r);
      canLoad = !mValid || r;
      g = modelGrant(m, s, v, mPtr);
      #1;
      checkOutput("rand in_ready", 32'(in_ready), (canLoad && g >= 0) ? (32'd1 << g) : 32'd0);
      @(posedge clk);
      if (canLoad && g >= 0) begin
         mValid = 1'b1;
         mData  = d[g*8 +: 8];
         mChan  = g;
         mPtr   = (g + 1) % N;
      end else if (mValid && r) begin
         mValid = 1'b0;
      end
      #1;
      checkOutput("rand out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("rand out_data", 32'(out_data), 32'(mData));
      checkOutput("rand out_chan", 32'(out_chan), 32'(mChan));
   endtask

   initial begin
      int cnt[4];
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0);
      #12;
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_data", 32'(out_data), 32'd0);
      checkOutput("reset out_chan", 32'(out_chan), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Hand-computed vectors. Channel data is ch0=11, ch1=22, ch2=33, ch3=44.
      // The comments track the round-robin pointer value after each vector.
      vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2}; // ptr 3
      vecs[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
      vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3}; // ptr 0
      vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0}; // ptr 1
      vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1}; // ptr 2
      vecs[5]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3}; // ptr 0
      vecs[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0}; // ptr 1
      vecs[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3}; // ptr 0
      vecs[8]  = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3}; // stall
      vecs[9]  = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
      vecs[10] = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
      vecs[11] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1}; // ptr 2
      vecs[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1}; // drain
      vecs[13] = '{1'b0, 2'd1, 4'b0001, 1'b0, 4'b0000, 1'b0, 8'h22, 2'd1}; // sel not valid
      vecs[14] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0}; // ptr 1
      vecs[15] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1}; // ptr moved in mode 0

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].valid,
                       {8'h44, 8'h33, 8'h22, 8'h11}, vecs[i].outReady);
         #1;
         checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].expData));
         checkOutput($sformatf("vec%0d out_chan", i), 32'(out_chan), 32'(vecs[i].expChan));
      end

      // Asynchronous reset while a word is held. The register must clear
      // before the next clock edge.
      applyStimulus(1'b0, 2'd0, 4'b0001, {8'h44, 8'h33, 8'h22, 8'hA5}, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
      checkOutput("pre-reset out_data", 32'(out_data), 32'hA5);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("async reset out_data", 32'(out_data), 32'd0);
      checkOutput("async reset out_chan", 32'(out_chan), 32'd0);

      // Round-robin fairness after reset: the grant order is 0,1,2,3,0,1.
      // Over the first four cycles, each ready bit is high exactly once.
      applyStimulus(1'b1, 2'd0, 4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int b = 0; b < 4; b++) cnt[b] = 0;
      for (int c = 0; c < 6; c++) begin
         checkOutput($sformatf("rr cycle%0d in_ready", c), 32'(in_ready), 32'd1 << (c % 4));
         if (c < 4)
            for (int b = 0; b < 4; b++) cnt[b] += int'(in_ready[b]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("rr cycle%0d out_chan", c), 32'(out_chan), 32'(c % 4));
      end
      for (int b = 0; b < 4; b++)
         checkOutput($sformatf("rr ready%0d count", b), 32'(cnt[b]), 32'd1);

      // Randomized traffic against the model, starting from a clean reset.
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0);
      #3;
      rst_n = 1'b1;
      mValid = 1'b0;
      mData  = 8'h00;
      mChan  = 0;
      mPtr   = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 400; i++) randomCycle();

`ifdef MUX_XFER_CNT_EN
      // Saturating counter: push more transfers than the counter can hold.
      rst_n = 1'b0;
      #1;
      checkOutput("xfer_cnt reset", 32'(xfer_cnt), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 2'd0, 4'b0001, 32'h0, 1'b1);
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      checkOutput("xfer_cnt saturated", 32'(xfer_cnt), 32'hFFFF);
      @(posedge clk);
      #1;
      checkOutput("xfer_cnt holds", 32'(xfer_cnt), 32'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
